// File: rtl/usrt_pkg.sv
// Shared USRT definitions: line levels, frame geometry and transmitter FSM encoding.
package usrt_pkg;

  localparam logic        USRT_IDLE_LVL  = 1'b1;
  localparam logic        USRT_START_LVL = 1'b0;
  localparam logic        USRT_STOP_LVL  = 1'b1;
  localparam int unsigned USRT_DATA_BITS = 8;

  // StParity is only reachable when the parity build option is enabled.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } usrt_tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic usrt_even_parity(input logic [USRT_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/usrt_tx_fifo.sv
// Byte FIFO in front of the USRT transmitter. DEPTH must be a power of two so the
// pointers wrap for free. Pushes while full and pops while empty are ignored.
module usrt_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset flushes the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/usrt_tx.sv
// USRT transmitter: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// The line changes on the rising clock edge; queued bytes are sent back-to-back with no idle gap.
// Build option: define USRT_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module usrt_tx
  import usrt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam logic [2:0] LastBit  = 3'(USRT_DATA_BITS - 1);
  localparam logic       StopLast = 1'(STOP_BITS - 1);

  usrt_tx_state_e state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           stop_cnt_q, stop_cnt_d;
  logic           tx_q, tx_d;
  logic           active_q, active_d;
  logic           done_q, done_d;
`ifdef USRT_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;

  usrt_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Rst_n),
    .push_i  (i_Tx_DV),
    .pop_i   (fifo_pop),
    .din_i   (i_Tx_Byte),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_Fifo_Count)
  );

  // Ready is plain !full; a pop in the same cycle does not make room early.
  assign o_Tx_Ready  = !fifo_full;
  assign o_Tx_Serial = tx_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  // Frame sequencer: every line level is registered so it changes only on the rising edge.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    active_d   = active_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
`ifdef USRT_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
`ifdef USRT_TX_PARITY_EN
          parity_d = usrt_even_parity(fifo_dout);
`endif
          tx_d     = USRT_START_LVL;
          active_d = 1'b1;
          state_d  = StStart;
        end
      end
      StStart: begin
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
        state_d   = StData;
      end
      StData: begin
        if (bit_cnt_q == LastBit) begin
`ifdef USRT_TX_PARITY_EN
          tx_d       = parity_q;
          state_d    = StParity;
`else
          tx_d       = USRT_STOP_LVL;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
`endif
        end else begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
`ifdef USRT_TX_PARITY_EN
      StParity: begin
        tx_d       = USRT_STOP_LVL;
        stop_cnt_d = 1'b0;
        state_d    = StStop;
      end
`endif
      StStop: begin
        if (stop_cnt_q == StopLast) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            // Chain straight into the next frame's start bit.
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
`ifdef USRT_TX_PARITY_EN
            parity_d = usrt_even_parity(fifo_dout);
`endif
            tx_d     = USRT_START_LVL;
            state_d  = StStart;
          end else begin
            tx_d     = USRT_IDLE_LVL;
            active_d = 1'b0;
            state_d  = StIdle;
          end
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d     = USRT_IDLE_LVL;
        active_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any frame and returns the line to idle at once.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= USRT_IDLE_LVL;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef USRT_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
`ifdef USRT_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
